fifo_burst_unpacker: RTL and testbench

- Sits between the I2C sensor master and the sample memory buffer.
- Captures one packed FIFO burst of up to 32 24-bit samples (768-bit word plus sample count) when the master raises data_ready.
- Emits the samples one at a time on a valid/ready stream, oldest (sample 0) first.
- Flags and counts bursts that arrive while a previous burst is still draining.

---
 rtl/fifo_burst_unpacker_if.sv | 35 +++
 rtl/fifo_burst_unpacker.sv | 101 ++++++++++
 tb/tb_fifo_burst_unpacker.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/fifo_burst_unpacker_if.sv
// Bundles the burst input side and the sample output stream of fifo_burst_unpacker.
// The slave modport belongs to the unpacker; master is the producer/consumer side.
interface fifo_burst_unpacker_if #(
    parameter int unsigned SAMPLE_W    = 24,
    parameter int unsigned MAX_SAMPLES = 32,
    parameter int unsigned NUM_W       = 6,
    parameter int unsigned DROP_W      = 8
);
    localparam int unsigned IDX_W = $clog2(MAX_SAMPLES);

    logic [SAMPLE_W*MAX_SAMPLES-1:0] fifo_data;
    logic [NUM_W-1:0]                num_samples;
    logic                            data_ready;
    logic [SAMPLE_W-1:0]             sample_data;
    logic                            sample_valid;
    logic                            sample_ready;
    logic [IDX_W-1:0]                sample_index;
    logic                            burst_done;
    logic                            busy;
    logic                            overflow;
    logic                            overflow_clr;
    logic [DROP_W-1:0]               dropped_count;

    modport master (
        output fifo_data, num_samples, data_ready, sample_ready, overflow_clr,
        input  sample_data, sample_valid, sample_index, burst_done, busy, overflow,
               dropped_count
    );

    modport slave (
        input  fifo_data, num_samples, data_ready, sample_ready, overflow_clr,
        output sample_data, sample_valid, sample_index, burst_done, busy, overflow,
               dropped_count
    );
endinterface

// File: rtl/fifo_burst_unpacker.sv
// Captures a packed burst of samples on a data_ready rising edge and replays it
// oldest-first on a valid/ready stream; bursts arriving mid-drain are dropped and counted.
module fifo_burst_unpacker #(
    parameter int unsigned SAMPLE_W    = 24,
    parameter int unsigned MAX_SAMPLES = 32,
    parameter int unsigned NUM_W       = 6,
    parameter int unsigned DROP_W      = 8
) (
    input logic                   clk,
    input logic                   reset,
    fifo_burst_unpacker_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(MAX_SAMPLES);
    localparam int unsigned DATA_W = SAMPLE_W * MAX_SAMPLES;

    typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   shadow_q, shadow_d;
    logic [NUM_W-1:0]    count_q, count_d;
    logic [IDX_W-1:0]    index_q, index_d;
    logic                dr_q;
    logic                overflow_q, overflow_d;
    logic [DROP_W-1:0]   dropped_q, dropped_d;

    logic                new_burst;
    logic                drop;
    logic                last;

    assign new_burst = bus.data_ready & ~dr_q;
    assign drop      = new_burst & (state_q != StIdle);
    assign last      = (NUM_W'(index_q) == count_q - NUM_W'(1));

    always_comb begin
        state_d = state_q;
        shadow_d = shadow_q;
        count_d = count_q;
        index_d = index_q;
        unique case (state_q)
            StIdle: begin
                if (new_burst && bus.num_samples != '0) begin
                    shadow_d = bus.fifo_data;
                    count_d  = (bus.num_samples > NUM_W'(MAX_SAMPLES)) ?
                               NUM_W'(MAX_SAMPLES) : bus.num_samples;
                    index_d  = '0;
                    state_d  = StStream;
                end
            end
            StStream: begin
                if (bus.sample_ready) begin
                    if (last) state_d = StDone;
                    else      index_d = index_q + IDX_W'(1);
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // A drop in the same cycle as a clear wins, leaving a fresh count of one.
    always_comb begin
        overflow_d = overflow_q;
        dropped_d  = dropped_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (bus.overflow_clr)       dropped_d = DROP_W'(1);
            else if (dropped_q != '1)   dropped_d = dropped_q + DROP_W'(1);
        end else if (bus.overflow_clr) begin
            overflow_d = 1'b0;
            dropped_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            shadow_q   <= '0;
            count_q    <= '0;
            index_q    <= '0;
            dr_q       <= 1'b1;
            overflow_q <= 1'b0;
            dropped_q  <= '0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            count_q    <= count_d;
            index_q    <= index_d;
            dr_q       <= bus.data_ready;
            overflow_q <= overflow_d;
            dropped_q  <= dropped_d;
        end
    end

    assign bus.sample_data   = shadow_q[index_q*SAMPLE_W +: SAMPLE_W];
    assign bus.sample_valid  = (state_q == StStream);
    assign bus.sample_index  = index_q;
    assign bus.burst_done    = (state_q == StDone);
    assign bus.busy          = (state_q != StIdle);
    assign bus.overflow      = overflow_q;
    assign bus.dropped_count = dropped_q;
endmodule

// File: tb/tb_fifo_burst_unpacker.sv
// Directed bench for fifo_burst_unpacker: bursts, backpressure, clamp, overflow, reset.
module tb_fifo_burst_unpacker;
    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_err = 0;

    fifo_burst_unpacker_if bus ();

    fifo_burst_unpacker dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Fill every slot with base+k, then raise data_ready; returns at the first stream cycle.
    task automatic start_burst(input logic [23:0] base, input int n_in);
        @(negedge clk);
        bus.data_ready = 1'b0;
        bus.num_samples = 6'(n_in);
        for (int k = 0; k < 32; k++) bus.fifo_data[24*k +: 24] = base + 24'(k);
        @(negedge clk);
        bus.data_ready = 1'b1;
        @(negedge clk);
        bus.fifo_data = ~bus.fifo_data;
        bus.num_samples = 6'd1;
    endtask

    task automatic do_burst(input logic [23:0] base, input int n_in, input int n_exp,
                            input int stall, input int g1, input int g2, input int clr_at);
        int idx = 0;
        bit done = 1'b0;
        start_burst(base, n_in);
        for (int cyc = 0; cyc < 120 && !done; cyc++) begin
            bus.sample_ready = (cyc >= stall);
            bus.data_ready = !(cyc == g1 || cyc == g2);
            bus.overflow_clr = (cyc == clr_at);
            if (bus.burst_done) begin
                done = 1'b1;
                check("done_count", idx, n_exp);
                check("done_valid", bus.sample_valid, 0);
            end else begin
                check("valid", bus.sample_valid, 1);
                check("data", bus.sample_data, base + 24'(idx));
                check("index", bus.sample_index, idx);
                if (bus.sample_ready) idx++;
            end
            @(negedge clk);
        end
        bus.overflow_clr = 1'b0;
        bus.sample_ready = 1'b1;
        if (!done) check("timeout", 0, 1);
        check("idle_after", bus.busy, 0);
        check("done_pulse", bus.burst_done, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bus.data_ready = 1'b1;
        bus.fifo_data = '0;
        bus.num_samples = '0;
        bus.sample_ready = 1'b1;
        bus.overflow_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", bus.sample_valid, 0);
        check("rst_done", bus.burst_done, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_ovf", bus.overflow, 0);
        check("rst_data", bus.sample_data, 0);
        check("rst_index", bus.sample_index, 0);
        check("rst_drop", bus.dropped_count, 0);

        // data_ready already high at release must not start a burst
        bus.num_samples = 6'd4;
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("hi_rel_valid", bus.sample_valid, 0);
            check("hi_rel_busy", bus.busy, 0);
        end

        do_burst(24'hA00000, 4, 4, 0, -1, -1, -1);
        do_burst(24'hA00000, 4, 4, 3, -1, -1, -1);
        do_burst(24'hC00000, 32, 32, 0, -1, -1, -1);
        do_burst(24'hD00000, 40, 32, 0, -1, -1, -1);

        start_burst(24'hE00000, 0);
        repeat (4) begin
            check("zero_valid", bus.sample_valid, 0);
            check("zero_done", bus.burst_done, 0);
            check("zero_busy", bus.busy, 0);
            @(negedge clk);
        end
        check("zero_ovf", bus.overflow, 0);

        do_burst(24'h100000, 32, 32, 0, 5, 20, -1);
        check("ovf_set", bus.overflow, 1);
        check("ovf_cnt2", bus.dropped_count, 2);
        do_burst(24'h200000, 8, 8, 0, 3, -1, 4);
        check("ovf_clr_drop", bus.overflow, 1);
        check("ovf_cnt1", bus.dropped_count, 1);
        bus.overflow_clr = 1'b1;
        @(negedge clk);
        bus.overflow_clr = 1'b0;
        check("ovf_clr", bus.overflow, 0);
        check("ovf_cnt0", bus.dropped_count, 0);

        start_burst(24'h300000, 8);
        bus.sample_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_index", bus.sample_index, 2);
        check("pre_rst_data", bus.sample_data, 24'h300002);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", bus.sample_valid, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_done", bus.burst_done, 0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_done", bus.burst_done, 0);
        do_burst(24'h400000, 5, 5, 0, -1, -1, -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
